// File: rtl/pc_unit.sv
// pc_unit: program counter with internal next-PC selection.
// Optional return-address stack built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_wre,
  input  logic             outside_load,
  input  logic [WIDTH-1:0] outside_pc,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] imm,
  input  logic [25:0]      jaddr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             call,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_udf
);

  localparam logic [2:0] SRC_SEQ = 3'd0;
  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_JMP = 3'd2;
  localparam logic [2:0] SRC_REG = 3'd3;
  localparam logic [2:0] SRC_RET = 3'd4;

  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] ret_tgt;
  logic [WIDTH-1:0] target;
  logic             wr;

  assign pc_plus4 = o_pc + WIDTH'(4);
  assign br_tgt   = pc_plus4 + (imm << 2);
  assign wr       = pc_wre && !outside_load;

  generate
    if (WIDTH == 28) begin : g_j28
      assign jmp_tgt = {jaddr, 2'b00};
    end else begin : g_jw
      assign jmp_tgt = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};
    end
  endgenerate

  // Next-PC target select; unused encodings fall back to sequential
  always_comb begin
    target = pc_plus4;
    case (pc_src)
      SRC_SEQ: target = pc_plus4;
      SRC_BR:  target = br_tgt;
      SRC_JMP: target = jmp_tgt;
      SRC_REG: target = rs_data;
      SRC_RET: target = ret_tgt;
      default: target = pc_plus4;
    endcase
  end

  // PC register: external load beats normal write; low bits cleared on write
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_pc     <= RESET_PC;
      misalign <= 1'b0;
    end else if (outside_load) begin
      o_pc     <= outside_pc;
      misalign <= 1'b0;
    end else if (pc_wre) begin
      o_pc     <= {target[WIDTH-1:2], 2'b00};
      misalign <= |target[1:0];
    end else begin
      misalign <= 1'b0;
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top;
  logic [PW:0]      cnt;
  logic             is_ret;

  assign top       = ptr - 1'b1;
  assign is_ret    = (pc_src == SRC_RET);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == (PW+1)'(RAS_DEPTH));
  assign ret_tgt   = ras_empty ? rs_data : ras[top];

  // Stack storage: pop+push rewrites the top, plain push writes next slot
  always_ff @(posedge clk) begin
    if (reset && wr && call) begin
      if (is_ret && !ras_empty) ras[top] <= pc_plus4;
      else                      ras[ptr] <= pc_plus4;
    end
  end

  // Pointer, occupancy and sticky error flags; ptr wraps over oldest
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      cnt     <= '0;
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else if (wr) begin
      if (is_ret && ras_empty) begin
        ras_udf <= 1'b1;
        if (call) begin
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
        end
      end else if (is_ret) begin
        if (!call) begin
          ptr <= top;
          cnt <= cnt - 1'b1;
        end
      end else if (call) begin
        ptr <= ptr + 1'b1;
        if (ras_full) ras_ovf <= 1'b1;
        else          cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic unused_call;

  assign unused_call = call;
  assign ret_tgt     = rs_data;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_ovf     = 1'b0;
  assign ras_udf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus multi-cycle RAS sequences.
// RAS sequences elaborate only when PC_RAS_EN is defined.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_wre;
  logic        outside_load;
  logic [31:0] outside_pc;
  logic [2:0]  pc_src;
  logic [31:0] imm;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic        call;
  logic [31:0] o_pc;
  logic [31:0] pc_plus4;
  logic        misalign;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_udf;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit #(
    .WIDTH(32),
    .RESET_PC(32'h0040_0000),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_wre(pc_wre),
    .outside_load(outside_load),
    .outside_pc(outside_pc),
    .pc_src(pc_src),
    .imm(imm),
    .jaddr(jaddr),
    .rs_data(rs_data),
    .call(call),
    .o_pc(o_pc),
    .pc_plus4(pc_plus4),
    .misalign(misalign),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_ovf(ras_ovf),
    .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] ldpc;
    logic        wre;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [25:0] ja;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic [31:0] ldpc,
                      input logic wre, input logic [2:0] src,
                      input logic [31:0] im, input logic [25:0] ja,
                      input logic [31:0] rs, input logic cl);
    outside_load = ld;
    outside_pc   = ldpc;
    pc_wre       = wre;
    pc_src       = src;
    imm          = im;
    jaddr        = ja;
    rs_data      = rs;
    call         = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic wre, input logic cl);
    reset = 1'b0;
    step(1'b0, 32'h0, wre, 3'd0, 32'h0, 26'h0, 32'h0, cl);
    reset = 1'b1;
  endtask

  task automatic load(input logic [31:0] v);
    step(1'b1, v, 1'b0, 3'd0, 32'h0, 26'h0, 32'h0, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    outside_load = 1'b0;
    outside_pc   = '0;
    pc_wre       = 1'b0;
    pc_src       = '0;
    imm          = '0;
    jaddr        = '0;
    rs_data      = '0;
    call         = 1'b0;

    vecs[0]  = '{1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0040_0004, 1'b0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0040_0008, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0040_000C, 1'b0};
    vecs[3]  = '{1'b1, 32'h100, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0000_0100, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 3'd1, 32'hFFFF_FFFE, 26'h0, 32'h0,
                 32'h0000_00FC, 1'b0};
    vecs[5]  = '{1'b1, 32'hF000_0000, 1'b0, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'hF000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0, 1'b1, 3'd2, 32'h0, 26'h10, 32'h0,
                 32'hF000_0040, 1'b0};
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 3'd3, 32'h0, 26'h0, 32'h203,
                 32'h0000_0200, 1'b1};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 3'd3, 32'h0, 26'h0, 32'h7,
                 32'h0000_0200, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 3'd1, 32'h1, 26'h0, 32'h0,
                 32'h0000_0208, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 3'd7, 32'h40, 26'h0, 32'h0,
                 32'h0000_020C, 1'b0};
    vecs[11] = '{1'b1, 32'h1235, 1'b1, 3'd3, 32'h0, 26'h0, 32'h3,
                 32'h0000_1235, 1'b0};
    vecs[12] = '{1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0000_1238, 1'b1};
    vecs[13] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'hFFFF_FFFC, 1'b0};
    vecs[14] = '{1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0,
                 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 32'h0, 1'b1, 3'd2, 32'h0, 26'h3FF_FFFF, 32'h0,
                 32'h0FFF_FFFC, 1'b0};

    // reset with pc_wre high
    do_reset(1'b1, 1'b0);
    check("rst_pc", o_pc, 32'h0040_0000);
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_full", 32'(ras_full), 32'd0);
    check("rst_ovf", 32'(ras_ovf), 32'd0);
    check("rst_udf", 32'(ras_udf), 32'd0);
    check("rst_mis", 32'(misalign), 32'd0);
    check("rst_p4", pc_plus4, 32'h0040_0004);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ld, vecs[i].ldpc, vecs[i].wre, vecs[i].src,
           vecs[i].imm, vecs[i].ja, vecs[i].rs, 1'b0);
      check($sformatf("vec%0d_pc", i), o_pc, vecs[i].epc);
      check($sformatf("vec%0d_mis", i), 32'(misalign),
            32'(vecs[i].emis));
    end
    check("tbl_empty", 32'(ras_empty), 32'd1);

    // hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0, 3'd1, 32'h5, 26'h1, 32'h9, 1'b0);
      check($sformatf("hold%0d", i), o_pc, 32'h0FFF_FFFC);
    end

`ifdef PC_RAS_EN
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      load(32'(i * 16));
      step(1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0, 1'b1);
      check($sformatf("call%0d_pc", i), o_pc, 32'(i * 16 + 4));
      if (i == 4) begin
        check("c4_full", 32'(ras_full), 32'd1);
        check("c4_ovf", 32'(ras_ovf), 32'd0);
      end
    end
    check("c5_full", 32'(ras_full), 32'd1);
    check("c5_ovf", 32'(ras_ovf), 32'd1);

    step(1'b1, 32'h1234, 1'b1, 3'd4, 32'h0, 26'h0, 32'h0, 1'b1);
    check("ldwre_pc", o_pc, 32'h0000_1234);
    check("ldwre_full", 32'(ras_full), 32'd1);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h000D_EAD0, 1'b0);
      check($sformatf("ret%0d_pc", i), o_pc, 32'h54 - 32'(i * 16));
    end
    check("ret_empty", 32'(ras_empty), 32'd1);
    check("ret_udf0", 32'(ras_udf), 32'd0);
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h800, 1'b0);
    check("udf_pc", o_pc, 32'h0000_0800);
    check("udf_flag", 32'(ras_udf), 32'd1);

    // reset between pushes with two entries held
    load(32'h10);
    step(1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0, 1'b1);
    check("two_empty", 32'(ras_empty), 32'd0);
    do_reset(1'b1, 1'b1);
    check("mid_pc", o_pc, 32'h0040_0000);
    check("mid_empty", 32'(ras_empty), 32'd1);
    check("mid_ovf", 32'(ras_ovf), 32'd0);
    check("mid_udf", 32'(ras_udf), 32'd0);
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h400, 1'b0);
    check("mid_ret", o_pc, 32'h0000_0400);

    // pop+push replaces the top entry
    do_reset(1'b0, 1'b0);
    load(32'h100);
    step(1'b0, 32'h0, 1'b1, 3'd0, 32'h0, 26'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h900, 1'b1);
    check("pp_pc", o_pc, 32'h0000_0104);
    check("pp_empty", 32'(ras_empty), 32'd0);
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h900, 1'b0);
    check("pp_ret", o_pc, 32'h0000_0108);
    check("pp_empty2", 32'(ras_empty), 32'd1);
    check("pp_udf", 32'(ras_udf), 32'd0);
`else
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h400, 1'b1);
    check("noras_pc", o_pc, 32'h0000_0400);
    check("noras_empty", 32'(ras_empty), 32'd1);
    check("noras_udf", 32'(ras_udf), 32'd0);
    step(1'b0, 32'h0, 1'b1, 3'd4, 32'h0, 26'h0, 32'h600, 1'b1);
    check("noras_pc2", o_pc, 32'h0000_0600);
    check("noras_full", 32'(ras_full), 32'd0);
    check("noras_ovf", 32'(ras_ovf), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle CPU, the successor to the original single-register PC. It holds the architectural PC and computes the next PC internally: sequential, branch, jump, register-indirect and return. An optional return-address stack (RAS) predicts return targets. It sits between the control unit, which drives `pc_wre` and `pc_src` in the IF/writeback state, and the instruction memory address port.

## Interface
- `WIDTH`, 32: PC width in bits; legal range 28..64.
- `RESET_PC`, 0: value loaded into `o_pc` on reset.
- `RAS_DEPTH`, 4: number of RAS entries, a power of two from 2 to 16.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `pc_wre` in 1: PC write enable from the control unit.
- `outside_load` in 1: force-load `outside_pc`; has priority over `pc_wre`.
- `outside_pc` in WIDTH: external load value (debug/boot).
- `pc_src` in 3: next-PC select: 0 = seq, 1 = branch, 2 = jump, 3 = register, 4 = return; 5–7 are treated as seq.
- `imm` in WIDTH: sign-extended branch word offset.
- `jaddr` in 26: jump word address.
- `rs_data` in WIDTH: register-indirect target.
- `call` in 1: push `pc_plus4` onto the RAS on a PC write.
- `o_pc` out WIDTH: current PC (registered).
- `pc_plus4` out WIDTH: `o_pc + 4` (combinational).
- `misalign` out 1: one-cycle pulse when a written target had nonzero bits [1:0].
- `ras_empty`, `ras_full` out 1: RAS occupancy flags.
- `ras_ovf`, `ras_udf` out 1: sticky overflow and underflow flags.

## Operation
- Target per `pc_src`:
  - seq: `pc_plus4`.
  - branch: `pc_plus4 + (imm << 2)`, truncated to WIDTH (wraps modulo 2^WIDTH).
  - jump: `{pc_plus4[WIDTH-1:28], jaddr, 2'b00}`; when WIDTH = 28, the target is `{jaddr, 2'b00}`.
  - register: `rs_data`.
  - return: RAS top entry if the RAS is non-empty, else `rs_data`.
- Update priority on each edge:
  1. `reset` low.
  2. `outside_load`.
  3. `pc_wre`.
  4. Hold.
- Reset: `o_pc` = RESET_PC, RAS count = 0, `ras_empty` = 1, `ras_full` = 0, `ras_ovf` = `ras_udf` = `misalign` = 0.
- `outside_load` writes `outside_pc` unmodified (no alignment check). RAS is untouched.
- `pc_wre` write: `o_pc` ← target with bits [1:0] forced to 0. `misalign` = 1 for the following cycle if the target's bits [1:0] were nonzero.
- RAS action only occurs when `pc_wre` = 1 and `outside_load` = 0:
  - Push (`call` = 1, `pc_src` ≠ 4): write `pc_plus4` at the top pointer, pointer + 1.
    - If count < DEPTH: count + 1.
    - If full: the oldest entry is overwritten (circular), count stays DEPTH, `ras_ovf` set.
  - Pop (`pc_src` = 4, `call` = 0):
    - Non-empty: pointer − 1, count − 1.
    - Empty: target is `rs_data`, `ras_udf` set, count stays 0.
  - Pop + push (`pc_src` = 4, `call` = 1): the top entry is replaced by `pc_plus4` after being used as the target; count unchanged. If empty, behaves as a push with target `rs_data` and sets `ras_udf`.
- Sticky flags clear only on reset.

## Timing
- `o_pc` changes one edge after `pc_wre`/`outside_load` are sampled high. When neither is high, `o_pc` holds indefinitely.
- `pc_plus4`, the target mux and the RAS top entry are combinational in the same cycle.
- RAS pointer, count and flags update on the same edge as `o_pc`.
- `misalign` is high for exactly one cycle after the offending write.
- `reset` low for one edge fully re-initialises the unit, even mid-push or mid-pop; other inputs are ignored that cycle.

## Configuration
- `PC_RAS_EN` defined: RAS is built as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage is built.
  - `pc_src` = 4 behaves exactly as 3.
  - `call` is ignored.
  - `ras_empty` = 1, `ras_full` = 0, `ras_ovf` = `ras_udf` = 0 constantly.

## Test plan
- Reset low with RESET_PC = 0x00400000, `pc_wre` = 1 -> `o_pc` = 0x00400000, `ras_empty` = 1, all flags 0. Then 3 seq writes -> 0x00400004, 0x00400008, 0x0040000C.
- `o_pc` = 0x100, branch with `imm` = 0xFFFFFFFE -> 0x0FC. Jump from 0xF0000000 with `jaddr` = 0x10 -> 0xF0000040. `rs_data` = 0x203 with register select -> `o_pc` = 0x200, `misalign` pulses for 1 cycle.
- RAS_DEPTH = 4 with 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> `ras_full` = 1, `ras_ovf` = 1. Then 4 returns -> 0x54, 0x44, 0x34, 0x24, then `ras_empty` = 1. A 5th return with `rs_data` = 0x800 -> 0x800, `ras_udf` = 1.
- `outside_load` and `pc_wre` both high with `outside_pc` = 0x1234 -> `o_pc` = 0x1234, RAS count unchanged. `pc_wre` = 0 for 10 cycles -> `o_pc` stable.
- Reset asserted between push cycles with 2 entries held -> count 0, flags cleared. The next return uses `rs_data`.
- Build without `PC_RAS_EN`: `pc_src` = 4 with `rs_data` = 0x400 -> `o_pc` = 0x400, `ras_empty` = 1, `ras_udf` = 0.
